// File: rtl/puc_pkg.sv
// Shared constants for the sequencer and the ALU: widths, opcodes,
// instruction field positions and the sequencer state type.
package puc_pkg;

   localparam int OPCODE_WIDTH   = 4;
   localparam int REGISTER_WIDTH = 8;
   localparam int PC_WIDTH       = 8;
   localparam int INSTR_WIDTH    = 16;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int R1_MSB  = 11;
   localparam int R1_LSB  = 10;
   localparam int R2_MSB  = 9;
   localparam int R2_LSB  = 8;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   localparam logic [OPCODE_WIDTH-1:0] OP_NOP        = 4'd0;
   localparam logic [OPCODE_WIDTH-1:0] OP_LOADSWITCH = 4'd1;
   localparam logic [OPCODE_WIDTH-1:0] OP_LOAD       = 4'd2;
   localparam logic [OPCODE_WIDTH-1:0] OP_ADD        = 4'd3;
   localparam logic [OPCODE_WIDTH-1:0] OP_LSHIFT     = 4'd4;
   localparam logic [OPCODE_WIDTH-1:0] OP_RSHIFT     = 4'd5;
   localparam logic [OPCODE_WIDTH-1:0] OP_INC        = 4'd6;
   localparam logic [OPCODE_WIDTH-1:0] OP_DECREMENT  = 4'd7;
   localparam logic [OPCODE_WIDTH-1:0] OP_JMP        = 4'd8;
   localparam logic [OPCODE_WIDTH-1:0] OP_JZ         = 4'd9;
   localparam logic [OPCODE_WIDTH-1:0] OP_HALT       = 4'd15;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      EXECUTE = 2'd1,
      PAUSE   = 2'd2,
      HALTED  = 2'd3
   } seq_state_e;

   // Opcodes whose result comes back from the ALU and is written to reg[r1].
   function automatic logic is_alu_op(input logic [OPCODE_WIDTH-1:0] op);
      return (op >= OP_LOADSWITCH) && (op <= OP_DECREMENT);
   endfunction

endpackage

// File: rtl/instruction_sequencer_if.sv
// Fetch bus and ALU operand/result bundle between the sequencer (master)
// and program memory plus ALU (slave).
interface instruction_sequencer_if;
   import puc_pkg::*;

   logic                      instrReq;
   logic [PC_WIDTH-1:0]       instrAddr;
   logic                      instrValid;
   logic [INSTR_WIDTH-1:0]    instrData;
   logic [OPCODE_WIDTH-1:0]   opCode;
   logic [REGISTER_WIDTH-1:0] register1Value;
   logic [REGISTER_WIDTH-1:0] register2Value;
   logic [REGISTER_WIDTH-1:0] instructionValue;
   logic [REGISTER_WIDTH-1:0] aluResult;

   modport master (
      output instrReq, instrAddr, opCode, register1Value, register2Value, instructionValue,
      input  instrValid, instrData, aluResult
   );

   modport slave (
      input  instrReq, instrAddr, opCode, register1Value, register2Value, instructionValue,
      output instrValid, instrData, aluResult
   );

endinterface

// File: rtl/instruction_sequencer_register_file.sv
// Four general registers: two combinational read ports, one synchronous
// write port, asynchronous active-low clear. reg[0] is also brought out
// directly for the board LEDs.
module register_file
   import puc_pkg::*;
(
   input  logic                      clock,
   input  logic                      resetN,
   input  logic                      wr_en,
   input  logic [1:0]                wr_addr,
   input  logic [REGISTER_WIDTH-1:0] wr_data,
   input  logic [1:0]                rd_addr1,
   input  logic [1:0]                rd_addr2,
   output logic [REGISTER_WIDTH-1:0] rd_data1,
   output logic [REGISTER_WIDTH-1:0] rd_data2,
   output logic [REGISTER_WIDTH-1:0] reg0
);

   logic [REGISTER_WIDTH-1:0] regs_q [4];
   logic [REGISTER_WIDTH-1:0] regs_d [4];

   assign rd_data1 = regs_q[rd_addr1];
   assign rd_data2 = regs_q[rd_addr2];
   assign reg0     = regs_q[0];

   // next register contents: one write per cycle
   always_comb begin
      regs_d = regs_q;
      if (wr_en) regs_d[wr_addr] = wr_data;
   end

   // register storage with asynchronous clear
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < 4; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

endmodule

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: fetches, decodes and executes one instruction per
// two cycles, driving an external combinational ALU and writing its result
// back to the register file. JMP/JZ/HALT are resolved locally.
// Optional build macro SEQ_SINGLE_STEP_EN adds a stepPulse input and a PAUSE
// state entered after every non-HALT instruction.
//
// state   | meaning
// FETCH   | instrReq high at pc, waiting for instrValid
// EXECUTE | latched instruction presented to ALU, write-back / pc update
// PAUSE   | single-step hold, waits for stepPulse (macro builds only)
// HALTED  | HALT executed, absorbing until reset
module instruction_sequencer
   import puc_pkg::*;
(
   input  logic                      clock,
   input  logic                      resetN,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic                      stepPulse,
`endif
   instruction_sequencer_if.master   bus,
   output logic                      halted,
   output logic [REGISTER_WIDTH-1:0] reg0Value
);

   seq_state_e                state_q,  state_d;
   logic [PC_WIDTH-1:0]       pc_q,     pc_d;
   logic [INSTR_WIDTH-1:0]    instr_q,  instr_d;
   logic [OPCODE_WIDTH-1:0]   opcode_q, opcode_d;
   logic                      halted_q, halted_d;

   logic [OPCODE_WIDTH-1:0]   exec_op;
   logic [1:0]                r1, r2;
   logic [REGISTER_WIDTH-1:0] imm;
   logic [REGISTER_WIDTH-1:0] rd1, rd2;
   logic                      wr_en;

   assign exec_op = instr_q[OP_MSB:OP_LSB];
   assign r1      = instr_q[R1_MSB:R1_LSB];
   assign r2      = instr_q[R2_MSB:R2_LSB];
   assign imm     = instr_q[IMM_MSB:IMM_LSB];

   register_file u_regs (
      .clock    (clock),
      .resetN   (resetN),
      .wr_en    (wr_en),
      .wr_addr  (r1),
      .wr_data  (bus.aluResult),
      .rd_addr1 (r1),
      .rd_addr2 (r2),
      .rd_data1 (rd1),
      .rd_data2 (rd2),
      .reg0     (reg0Value)
   );

   // instrReq is gated by resetN so it is low for the whole reset, even
   // though the state register already sits in FETCH.
   assign bus.instrReq         = resetN && (state_q == FETCH);
   assign bus.instrAddr        = pc_q;
   assign bus.opCode           = opcode_q;
   assign bus.register1Value   = rd1;
   assign bus.register2Value   = rd2;
   assign bus.instructionValue = imm;
   assign halted               = halted_q;

   // next-state, pc, latch and write-back decode
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      opcode_d = OP_NOP;
      halted_d = halted_q;
      wr_en    = 1'b0;
      unique case (state_q)
         FETCH: begin
            if (bus.instrValid) begin
               instr_d  = bus.instrData;
               opcode_d = bus.instrData[OP_MSB:OP_LSB];
               state_d  = EXECUTE;
            end
         end
         EXECUTE: begin
`ifdef SEQ_SINGLE_STEP_EN
            state_d = PAUSE;
`else
            state_d = FETCH;
`endif
            case (exec_op)
               OP_JMP:  pc_d = imm;
               OP_JZ:   pc_d = (rd1 == '0) ? imm : pc_q + 1'b1;
               OP_HALT: begin
                  state_d  = HALTED;
                  halted_d = 1'b1;
               end
               default: begin
                  pc_d  = pc_q + 1'b1;
                  wr_en = is_alu_op(exec_op);
               end
            endcase
         end
         PAUSE: begin
`ifdef SEQ_SINGLE_STEP_EN
            if (stepPulse) state_d = FETCH;
`else
            state_d = FETCH;
`endif
         end
         HALTED: state_d = HALTED;
      endcase
   end

   // sequencer state and registered outputs
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q  <= FETCH;
         pc_q     <= '0;
         instr_q  <= '0;
         opcode_q <= OP_NOP;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         opcode_q <= opcode_d;
         halted_q <= halted_d;
      end
   end

endmodule
